// File: rtl/dlx_pkg.sv
// Shared DLX core types and constants for the GPR write-back path.
// Holds register/data widths, the write-back entry struct and defaults.
package dlx_pkg;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  localparam int WB_DEPTH        = 2;
  localparam int WB_STARVE_LIMIT = 8;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/gpr_wb_fifo.sv
// Small synchronous FIFO holding MDU results awaiting the GPR write port.
// Push is dropped when full and pop is ignored when empty.
module gpr_wb_fifo
  import dlx_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  wb_entry_t     i_data,
  input  logic          i_pop,
  output wb_entry_t     o_head,
  output logic [CW-1:0] o_count
);

  wb_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && (r_cnt != CW'(DEPTH));
  assign w_pop   = i_pop && (r_cnt != '0);
  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the GPR write port between WB and the MDU, tracks outstanding
// MDU destinations and stalls decode on hazards or FIFO starvation.
module gpr_wb_arbiter
  import dlx_pkg::*;
#(
  parameter  int DEPTH        = WB_DEPTH,
  parameter  int STARVE_LIMIT = WB_STARVE_LIMIT,
  localparam int CW           = $clog2(DEPTH) + 1,
  localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [REG_W-1:0]  pipe_ws,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic [REG_W-1:0]  dec_rs1,
  input  logic [REG_W-1:0]  dec_rs2,
  input  logic [REG_W-1:0]  dec_rd,
  input  logic              dec_rd_valid,
  input  logic              mdu_issue,
  input  logic              mdu_valid,
  input  logic [REG_W-1:0]  mdu_rd,
  input  logic [DATA_W-1:0] mdu_wdata,
  output logic              mdu_ready,
  output logic              gpr_we,
  output logic [REG_W-1:0]  gpr_ws,
  output logic [DATA_W-1:0] gpr_wdata,
  output logic              stall,
  output logic [NUM_REGS-1:0] busy,
  output logic [CW-1:0]     fifo_count
);

  wb_entry_t           w_head;
  wb_entry_t           w_in;
  logic                w_nonempty;
  logic                w_pop;
  logic                w_push;
  logic                w_starve;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [NUM_REGS-1:0] r_busy;
  logic [SW-1:0]       r_starve_cnt;

  assign w_in       = '{rd: mdu_rd, data: mdu_wdata};
  assign mdu_ready  = fifo_count < CW'(DEPTH);
  assign w_nonempty = fifo_count != '0;
  assign w_pop      = !pipe_we && w_nonempty;
  assign w_push     = mdu_valid && mdu_ready;

  gpr_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (fifo_count)
  );

  // Pipeline always wins; r0 writes are squashed but the head still pops.
  always_comb begin
    gpr_we    = 1'b0;
    gpr_ws    = '0;
    gpr_wdata = '0;
    if (!rst) begin
      if (pipe_we) begin
        gpr_we    = pipe_ws != '0;
        gpr_ws    = pipe_ws;
        gpr_wdata = pipe_wdata;
      end else if (w_nonempty) begin
        gpr_we    = w_head.rd != '0;
        gpr_ws    = w_head.rd;
        gpr_wdata = w_head.data;
      end
    end
  end

  assign w_starve = (r_starve_cnt == SW'(STARVE_LIMIT)) && w_nonempty;
  assign stall    = r_busy[dec_rs1] | r_busy[dec_rs2]
                  | (dec_rd_valid & r_busy[dec_rd]) | w_starve;
  assign busy     = r_busy;

  // Set is applied after clear so a coincident set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) w_busy_nxt[w_head.rd] = 1'b0;
    if (mdu_issue && !stall && dec_rd != '0)
      w_busy_nxt[dec_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy       <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (!w_nonempty || w_pop)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != SW'(STARVE_LIMIT))
        r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed and randomized bench for gpr_wb_arbiter.
// A queue-based reference model predicts every output each cycle.
module tb_gpr_wb_arbiter;
  import dlx_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_ws;
  logic [31:0] pipe_wdata;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_rd_valid;
  logic        mdu_issue;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_wdata;
  logic        mdu_ready;
  logic        gpr_we;
  logic [4:0]  gpr_ws;
  logic [31:0] gpr_wdata;
  logic        stall;
  logic [31:0] busy;
  logic [1:0]  fifo_count;

  int tests = 0;
  int fails = 0;

  wb_entry_t   q[$];
  logic [31:0] mbusy;
  int          scnt;

  gpr_wb_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_we      (pipe_we),
    .pipe_ws      (pipe_ws),
    .pipe_wdata   (pipe_wdata),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .dec_rd_valid (dec_rd_valid),
    .mdu_issue    (mdu_issue),
    .mdu_valid    (mdu_valid),
    .mdu_rd       (mdu_rd),
    .mdu_wdata    (mdu_wdata),
    .mdu_ready    (mdu_ready),
    .gpr_we       (gpr_we),
    .gpr_ws       (gpr_ws),
    .gpr_wdata    (gpr_wdata),
    .stall        (stall),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic mstall();
    logic s;
    s = mbusy[dec_rs1] | mbusy[dec_rs2];
    s = s | (dec_rd_valid & mbusy[dec_rd]);
    s = s | (scnt == LIMIT && q.size() > 0);
    return s;
  endfunction

  task automatic check_all();
    logic        ewe;
    logic [31:0] ews;
    logic [31:0] ewd;
    ewe = 1'b0;
    ews = '0;
    ewd = '0;
    if (pipe_we) begin
      ewe = pipe_ws != 0;
      ews = 32'(pipe_ws);
      ewd = pipe_wdata;
    end else if (q.size() > 0) begin
      ewe = q[0].rd != 0;
      ews = 32'(q[0].rd);
      ewd = q[0].data;
    end
    chk("gpr_we", 32'(gpr_we), 32'(ewe));
    chk("gpr_ws", 32'(gpr_ws), ews);
    chk("gpr_wdata", gpr_wdata, ewd);
    chk("stall", 32'(stall), 32'(mstall()));
    chk("busy", busy, mbusy);
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("mdu_ready", 32'(mdu_ready),
        32'(q.size() < DEPTH));
  endtask

  task automatic model_edge();
    logic      st;
    logic      pop;
    logic      push;
    int        n;
    wb_entry_t e;
    if (rst) begin
      q.delete();
      mbusy = '0;
      scnt  = 0;
    end else begin
      st   = mstall();
      n    = q.size();
      pop  = !pipe_we && n > 0;
      push = mdu_valid && n < DEPTH;
      if (pop) begin
        e = q.pop_front();
        mbusy[e.rd] = 1'b0;
      end
      if (mdu_issue && !st && dec_rd != 0)
        mbusy[dec_rd] = 1'b1;
      mbusy[0] = 1'b0;
      if (push) q.push_back('{rd: mdu_rd, data: mdu_wdata});
      if (n == 0 || pop) scnt = 0;
      else if (scnt < LIMIT) scnt++;
    end
  endtask

  task automatic tick();
    #1;
    if (!rst) check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_in();
    pipe_we      = 0;
    pipe_ws      = 0;
    pipe_wdata   = 0;
    dec_rs1      = 0;
    dec_rs2      = 0;
    dec_rd       = 0;
    dec_rd_valid = 0;
    mdu_issue    = 0;
    mdu_valid    = 0;
    mdu_rd       = 0;
    mdu_wdata    = 0;
  endtask

  initial begin
    int first;
    mbusy = '0;
    scnt  = 0;
    idle_in();
    rst = 1;
    @(negedge clk);
    tick();
    tick();
    rst = 0;
    #1;
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ready", 32'(mdu_ready), 1);
    chk("rst_busy", busy, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_we", 32'(gpr_we), 0);
    tick();

    // 1: pipeline beats FIFO head
    pipe_we   = 1;
    pipe_ws   = 1;
    mdu_valid = 1;
    mdu_rd    = 3;
    mdu_wdata = 32'h55;
    tick();
    mdu_valid  = 0;
    pipe_ws    = 7;
    pipe_wdata = 32'hDEADBEEF;
    #1;
    chk("t1_ws", 32'(gpr_ws), 7);
    chk("t1_wd", gpr_wdata, 32'hDEADBEEF);
    tick();
    chk("t1_cnt", 32'(fifo_count), 1);
    pipe_we = 0;
    #1;
    chk("t1_ws3", 32'(gpr_ws), 3);
    tick();
    chk("t1_empty", 32'(fifo_count), 0);

    // 2: scoreboard hazard
    idle_in();
    mdu_issue    = 1;
    dec_rd       = 5;
    dec_rd_valid = 1;
    tick();
    idle_in();
    dec_rs1 = 5;
    #1;
    chk("t2_busy5", 32'(busy[5]), 1);
    chk("t2_stall", 32'(stall), 1);
    mdu_valid = 1;
    mdu_rd    = 5;
    mdu_wdata = 32'h12;
    tick();
    mdu_valid = 0;
    #1;
    chk("t2_wr_ws", 32'(gpr_ws), 5);
    chk("t2_wr_wd", gpr_wdata, 32'h12);
    chk("t2_wr_st", 32'(stall), 1);
    tick();
    chk("t2_clr", busy, 0);
    chk("t2_go", 32'(stall), 0);
    tick();

    // 3: FIFO full backpressure
    idle_in();
    pipe_we   = 1;
    pipe_ws   = 2;
    mdu_valid = 1;
    for (int i = 0; i < 3; i++) begin
      mdu_rd    = 5'(10 + i);
      mdu_wdata = 32'(100 + i);
      tick();
    end
    chk("t3_cnt", 32'(fifo_count), 2);
    chk("t3_rdy", 32'(mdu_ready), 0);
    pipe_we = 0;
    tick();
    tick();
    mdu_valid = 0;
    tick();
    tick();
    tick();
    chk("t3_drained", 32'(fifo_count), 0);

    // 4: starvation
    idle_in();
    pipe_we   = 1;
    pipe_ws   = 1;
    mdu_valid = 1;
    mdu_rd    = 4;
    tick();
    mdu_valid = 0;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      #1;
      if (stall && first < 0) first = i;
      tick();
    end
    chk("t4_cycle", 32'(first), 9);
    pipe_we = 0;
    tick();
    #1;
    chk("t4_st_off", 32'(stall), 0);
    chk("t4_cnt", 32'(fifo_count), 0);
    tick();

    // 5: r0 writes
    idle_in();
    pipe_we   = 1;
    pipe_ws   = 3;
    mdu_valid = 1;
    mdu_rd    = 0;
    mdu_wdata = 32'h77;
    tick();
    idle_in();
    #1;
    chk("t5_we0", 32'(gpr_we), 0);
    tick();
    chk("t5_pop", 32'(fifo_count), 0);
    mdu_issue = 1;
    tick();
    mdu_issue = 0;
    #1;
    chk("t5_busy", busy, 0);
    tick();

    // 6: reset mid-operation
    idle_in();
    pipe_we      = 1;
    pipe_ws      = 6;
    mdu_valid    = 1;
    mdu_rd       = 12;
    mdu_issue    = 1;
    dec_rd       = 9;
    dec_rd_valid = 1;
    tick();
    mdu_issue = 0;
    tick();
    chk("t6_pre_cnt", 32'(fifo_count), 2);
    chk("t6_pre_b9", 32'(busy[9]), 1);
    rst = 1;
    tick();
    rst = 0;
    idle_in();
    #1;
    chk("t6_cnt", 32'(fifo_count), 0);
    chk("t6_busy", busy, 0);
    chk("t6_stall", 32'(stall), 0);
    chk("t6_we", 32'(gpr_we), 0);
    chk("t6_rdy", 32'(mdu_ready), 1);
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int hi;
      hi = ((i / 100) % 2) ? 10 : 5;
      rst          = $urandom_range(0, 149) == 0;
      pipe_we      = $urandom_range(0, 9) < hi;
      pipe_ws      = 5'($urandom_range(0, 7));
      pipe_wdata   = $urandom;
      dec_rs1      = 5'($urandom_range(0, 7));
      dec_rs2      = 5'($urandom_range(0, 7));
      dec_rd       = 5'($urandom_range(0, 7));
      dec_rd_valid = 1'($urandom_range(0, 1));
      mdu_issue    = $urandom_range(0, 3) == 0;
      mdu_valid    = $urandom_range(0, 2) == 0;
      mdu_rd       = 5'($urandom_range(0, 7));
      mdu_wdata    = $urandom;
      tick();
    end
    rst = 0;
    idle_in();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
